// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
package fifo_pkg;

    // Entries in the read-side output buffer.
    localparam int RD_BUF_DEPTH = 2;

    // Occupancy states of the read-side output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } rd_buf_state_e;

    // Number of buffered beats represented by a buffer state.
    function automatic logic [1:0] state_count(rd_buf_state_e s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            EMPTY:   n = 2'd0;
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rd_skid_buffer.sv
// Two-entry output buffer: ring of two slots with head/tail indices.
// The occupancy FSM state is exported so checkers can observe it.
module rd_skid_buffer
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [WIDTH-1:0]    push_data_i,
    input  logic                pop_i,
    output logic                valid_o,
    output logic [WIDTH-1:0]    data_o,
    output rd_buf_state_e       state_o
);

    rd_buf_state_e    state_q;
    logic [WIDTH-1:0] slot_q [RD_BUF_DEPTH];
    logic             head_q;
    logic             tail_q;
    logic             do_pop;
    logic             do_push;

    // A pop needs a stored beat; a push needs a free slot, which a same-cycle pop provides.
    always_comb begin
        do_pop  = pop_i & (state_q != EMPTY);
        do_push = push_i & ((state_q != TWO) | do_pop);
    end

    // Occupancy FSM, slot storage and ring indices.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                slot_q[tail_q] <= push_data_i;
                tail_q         <= ~tail_q;
            end
            if (do_pop) begin
                head_q <= ~head_q;
            end
            case (state_q)
                EMPTY: if (do_push) state_q <= ONE;
                ONE: begin
                    if (do_push && !do_pop)      state_q <= TWO;
                    else if (do_pop && !do_push) state_q <= EMPTY;
                end
                TWO: if (do_pop && !do_push) state_q <= ONE;
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Head slot is presented directly; it only moves on a pop, so it holds under backpressure.
    always_comb begin
        valid_o = (state_q != EMPTY);
        data_o  = slot_q[head_q];
        state_o = state_q;
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: drains a 1-cycle-latency FIFO read port into a
// valid/ready stream through a 2-entry buffer.
//
// Handshake: a beat transfers on a rising clk_i edge where m_valid_o and
// m_ready_i are both 1. Once m_valid_o is raised it and m_data_o hold until
// that transfer; m_valid_o never depends on m_ready_i.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clear_i,
    output logic                 fifo_rd_en_o,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_empty_i,
    input  logic                 fifo_rd_error_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic [CNT_WIDTH-1:0] beat_cnt_o,
    output logic                 rd_error_o
);

    rd_buf_state_e buf_state;
    logic [1:0]    buf_count;
    logic          pending_q;
    logic          pop;
    logic          capture;
    logic          rd_fault;
    logic [2:0]    credit_used;
    logic [2:0]    credit_limit;

    // Credit rule: buffered plus in-flight beats, less the beat leaving now, must stay below depth.
    always_comb begin
        buf_count    = state_count(buf_state);
        pop          = m_valid_o & m_ready_i;
        capture      = pending_q & ~fifo_rd_error_i;
        rd_fault     = pending_q & fifo_rd_error_i;
        credit_used  = {1'b0, buf_count} + {2'b00, pending_q};
        credit_limit = 3'(RD_BUF_DEPTH) + {2'b00, pop};
        fifo_rd_en_o = rst_ni & en_i & ~fifo_empty_i & (credit_used < credit_limit);
    end

    // Remember that a read was issued so its data is captured next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pending_q <= 1'b0;
        else         pending_q <= fifo_rd_en_o;
    end

    // Delivered-beat counter and sticky read-error flag; clear wins over same-cycle events.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_o <= '0;
            rd_error_o <= 1'b0;
        end else if (clear_i) begin
            beat_cnt_o <= '0;
            rd_error_o <= 1'b0;
        end else begin
            if (pop)      beat_cnt_o <= beat_cnt_o + 1'b1;
            if (rd_fault) rd_error_o <= 1'b1;
        end
    end

    rd_skid_buffer #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (capture),
        .push_data_i (fifo_rdata_i),
        .pop_i       (pop),
        .valid_o     (m_valid_o),
        .data_o      (m_data_o),
        .state_o     (buf_state)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        exp_rd_en;
        logic        exp_valid;
        logic        chk_data;
        logic [7:0]  exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        rdy = 1'b0;
    logic        force_err = 1'b0;
    logic        fifo_rd_en;
    logic        fifo_rd_err;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [15:0] beat_cnt;
    logic        rd_error;

    // ---------------- FIFO model (1-cycle read latency) ----------------
    logic        f_wr = 1'b0;
    logic [7:0]  f_wdata = 8'h00;
    logic [7:0]  f_mem [16];
    logic [3:0]  f_wp, f_rp;
    logic [4:0]  f_cnt;
    logic [7:0]  f_rdata;
    logic        f_err;
    logic        f_empty;
    logic        f_rd_ok;

    assign f_empty     = (f_cnt == 5'd0);
    assign f_rd_ok     = fifo_rd_en && !f_empty;
    assign fifo_rd_err = f_err | force_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_wp <= 4'd0; f_rp <= 4'd0; f_cnt <= 5'd0; f_rdata <= 8'h00; f_err <= 1'b0;
        end else begin
            if (f_wr) begin
                f_mem[f_wp] <= f_wdata;
                f_wp <= f_wp + 4'd1;
            end
            if (f_rd_ok) begin
                f_rdata <= f_mem[f_rp];
                f_rp <= f_rp + 4'd1;
            end
            f_err <= fifo_rd_en && f_empty;
            f_cnt <= f_cnt + {4'd0, f_wr} - {4'd0, f_rd_ok};
        end
    end

    fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .en_i            (en),
        .clear_i         (clr),
        .fifo_rd_en_o    (fifo_rd_en),
        .fifo_rdata_i    (f_rdata),
        .fifo_empty_i    (f_empty),
        .fifo_rd_error_i (fifo_rd_err),
        .m_valid_o       (m_valid),
        .m_ready_i       (rdy),
        .m_data_o        (m_data),
        .beat_cnt_o      (beat_cnt),
        .rd_error_o      (rd_error)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;
    int model_err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: record delivered beats, read strobes, FIFO read errors, buffer bound.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && rdy) got_q.push_back(m_data);
            if (fifo_rd_en) rd_cnt++;
            if (f_err) model_err_cnt++;
            if (dut.buf_count > 2'd2) check("buf_count_le2", {30'd0, dut.buf_count}, 32'd2);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; rdy = 1'b0; clr = 1'b0; force_err = 1'b0; f_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        rd_cnt = 0;
        model_err_cnt = 0;
    endtask

    task automatic fifo_push(input logic [7:0] d);
        f_wr = 1'b1;
        f_wdata = d;
        @(posedge clk);
        #1 f_wr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];

    initial begin
        int rd_first, v_first, waited;
        logic stall_bad;
        logic [7:0] v_data;

        // Test 1 expectations: 0x11..0x14 preloaded, ready held high.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 16'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 16'd2};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h14, 16'd3};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd4};

        // ---- reset values ----
        do_reset();
        @(negedge clk);
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_data", {24'd0, m_data}, 32'd0);
        check("rst_cnt", {16'd0, beat_cnt}, 32'd0);
        check("rst_err", {31'd0, rd_error}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        step();

        // ---- test 1: table-driven streaming ----
        for (int i = 0; i < 4; i++) fifo_push(8'h11 + 8'(i));
        for (int i = 0; i < 7; i++) begin
            en = vecs[i].en;
            rdy = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("t1_rd_en[%0d]", i), {31'd0, fifo_rd_en}, {31'd0, vecs[i].exp_rd_en});
            check($sformatf("t1_valid[%0d]", i), {31'd0, m_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].chk_data)
                check($sformatf("t1_data[%0d]", i), {24'd0, m_data}, {24'd0, vecs[i].exp_data});
            check($sformatf("t1_cnt[%0d]", i), {16'd0, beat_cnt}, {16'd0, vecs[i].exp_cnt});
            step();
        end

        // ---- test 2: backpressure stall with 8 beats ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fifo_push(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        rd_cnt = 0;
        en = 1'b1;
        rdy = 1'b0;
        stall_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2 && (!m_valid || m_data !== 8'h20)) stall_bad = 1'b1;
            step();
        end
        check("t2_stall_reads", rd_cnt, 32'd2);
        check("t2_stall_stable", {31'd0, stall_bad}, 32'd0);
        rdy = 1'b1;
        waited = 0;
        while (got_q.size() < 8 && waited < 40) begin
            step();
            waited++;
        end
        check("t2_beats", got_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size())
                check($sformatf("t2_order[%0d]", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        check("t2_total_reads", rd_cnt, 32'd8);
        check("t2_beat_cnt", {16'd0, beat_cnt}, 32'd8);

        // ---- test 3: single beat into an empty FIFO ----
        do_reset();
        en = 1'b1;
        rdy = 1'b0;
        step();
        step();
        fifo_push(8'hA5);
        rd_first = -1;
        v_first = -1;
        v_data = 8'h00;
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_rd_en && rd_first < 0) rd_first = i;
            if (m_valid && v_first < 0) begin
                v_first = i;
                v_data = m_data;
            end
            step();
        end
        check("t3_rd_pulses", rd_cnt, 32'd1);
        check("t3_latency", v_first - rd_first, 32'd2);
        check("t3_data", {24'd0, v_data}, 32'h0000_00A5);
        check("t3_fifo_err", model_err_cnt, 32'd0);

        // ---- test 4: forced read error, then clear with a pop ----
        do_reset();
        fifo_push(8'h31);
        fifo_push(8'h32);
        en = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        check("t4_rd_c0", {31'd0, fifo_rd_en}, 32'd1);
        step();
        force_err = 1'b1;
        @(negedge clk);
        check("t4_rd_c1", {31'd0, fifo_rd_en}, 32'd1);
        step();
        force_err = 1'b0;
        @(negedge clk);
        check("t4_err_set", {31'd0, rd_error}, 32'd1);
        check("t4_dropped", {31'd0, m_valid}, 32'd0);
        step();
        clr = 1'b1;
        @(negedge clk);
        check("t4_err_sticky", {31'd0, rd_error}, 32'd1);
        check("t4_valid_c3", {31'd0, m_valid}, 32'd1);
        check("t4_data_c3", {24'd0, m_data}, 32'h0000_0032);
        step();
        clr = 1'b0;
        @(negedge clk);
        check("t4_clr_cnt", {16'd0, beat_cnt}, 32'd0);
        check("t4_clr_err", {31'd0, rd_error}, 32'd0);
        step();

        // ---- test 5: en_i low mid-stream, then asynchronous reset ----
        do_reset();
        for (int i = 0; i < 6; i++) fifo_push(8'h40 + 8'(i));
        rd_cnt = 0;
        en = 1'b1;
        rdy = 1'b1;
        step();
        step();
        step();
        en = 1'b0;
        @(negedge clk);
        check("t5_rd_stop", {31'd0, fifo_rd_en}, 32'd0);
        for (int i = 0; i < 8; i++) step();
        check("t5_reads", rd_cnt, 32'd3);
        check("t5_drained", got_q.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size())
                check($sformatf("t5_order[%0d]", i), {24'd0, got_q[i]}, 32'h40 + 32'(i));
        end
        en = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t5_pre_valid", {31'd0, m_valid}, 32'd1);
        check("t5_pre_data", {24'd0, m_data}, 32'h0000_0043);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_arst_valid", {31'd0, m_valid}, 32'd0);
        check("t5_arst_data", {24'd0, m_data}, 32'd0);
        check("t5_arst_cnt", {16'd0, beat_cnt}, 32'd0);
        check("t5_arst_err", {31'd0, rd_error}, 32'd0);
        check("t5_arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        en = 1'b0;
        step();
        #1 rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
